// File: rtl/crc8_lfsr.sv
// Serial CRC generator: absorbs one message bit per clock while Active is high,
// then shifts the CRC out LSB first with Valid asserted for CRC_WIDTH cycles.
module crc8_lfsr #(
    parameter int unsigned           CRC_WIDTH = 8,
    parameter logic [CRC_WIDTH-1:0]  SEED      = CRC_WIDTH'(8'hD8),
    parameter logic [CRC_WIDTH-1:0]  TAPS      = CRC_WIDTH'(8'b0100_0100)
) (
    input  logic CLK,
    input  logic RST,
    input  logic DATA,
    input  logic Active,
    output logic CRC,
    output logic Valid
);

    localparam int unsigned CNT_W = (CRC_WIDTH > 1) ? $clog2(CRC_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CRC_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_SHIFT
    } state_t;

    state_t               state;
    logic [CRC_WIDTH-1:0] lfsr;
    logic [CRC_WIDTH-1:0] lfsr_absorb;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 fb;

    // Top tap bit is implicit: the feedback always lands in the MSB.
    always_comb begin
        lfsr_absorb = '0;
        fb          = lfsr[0] ^ DATA;
        for (int unsigned i = 0; i < CRC_WIDTH - 1; i++) begin
            lfsr_absorb[i] = lfsr[i+1] ^ (TAPS[i] & fb);
        end
        lfsr_absorb[CRC_WIDTH-1] = fb;
    end

    // Active has priority: re-asserting it mid-output aborts the burst and the
    // partially shifted register keeps absorbing without a reload.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lfsr    <= SEED;
            CRC     <= 1'b0;
            Valid   <= 1'b0;
            bit_cnt <= '0;
            state   <= ST_IDLE;
        end else if (Active) begin
            lfsr    <= lfsr_absorb;
            CRC     <= 1'b0;
            Valid   <= 1'b0;
            bit_cnt <= '0;
            state   <= ST_PEND;
        end else if (state != ST_IDLE) begin
            CRC   <= lfsr[0];
            Valid <= 1'b1;
            lfsr  <= {1'b0, lfsr[CRC_WIDTH-1:1]};
            if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= ST_IDLE;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                state   <= ST_SHIFT;
            end
        end else begin
            CRC   <= 1'b0;
            Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_crc8_lfsr.sv
// Bench for crc8_lfsr: directed and random messages checked against an
// arithmetic model of the CRC feedback rule.
module tb_crc8_lfsr;

    localparam logic [7:0] P_SEED = 8'hD8;
    localparam logic [7:0] P_TAPS = 8'h44;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic DATA = 1'b0;
    logic Active = 1'b0;
    logic CRC;
    logic Valid;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] m;

    crc8_lfsr #(
        .CRC_WIDTH(8),
        .SEED(P_SEED),
        .TAPS(P_TAPS)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .DATA(DATA),
        .Active(Active),
        .CRC(CRC),
        .Valid(Valid)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] ref_step(input logic [7:0] l, input logic d);
        logic f;
        f = l[0] ^ d;
        return (l >> 1) ^ (f ? (8'h80 | P_TAPS) : 8'h00);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        Active = 1'b0;
        DATA = 1'b0;
        m = P_SEED;
        step();
        chk("reset_valid", {31'd0, Valid}, 32'd0);
        chk("reset_crc", {31'd0, CRC}, 32'd0);
        RST = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            Active = 1'b1;
            DATA = b[i];
            step();
            m = ref_step(m, b[i]);
            chk("compute_valid", {31'd0, Valid}, 32'd0);
            chk("compute_crc", {31'd0, CRC}, 32'd0);
        end
    endtask

    task automatic drain(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = '0;
        Active = 1'b0;
        DATA = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk({tag, "_valid_hi"}, {31'd0, Valid}, 32'd1);
            chk({tag, "_bit"}, {31'd0, CRC}, {31'd0, m[0]});
            got[k] = CRC;
            m = m >> 1;
        end
        step();
        chk({tag, "_valid_lo"}, {31'd0, Valid}, 32'd0);
        chk({tag, "_crc_lo"}, {31'd0, CRC}, 32'd0);
        chk({tag, "_word"}, {24'd0, got}, {24'd0, exp});
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] e;

        // Known answers
        do_reset();
        send_byte(8'h00, 8);
        chk("zeros_model", {24'd0, m}, 32'h14);
        drain("zeros", 8'h14);

        do_reset();
        send_byte(8'hFF, 8);
        chk("ones_model", {24'd0, m}, 32'h72);
        drain("ones", 8'h72);

        // Random bytes, LSB first, each after a reset
        for (int r = 0; r < 10; r++) begin
            b = 8'($urandom);
            do_reset();
            send_byte(b, 8);
            e = m;
            drain("rand", e);
        end

        // Reset mid-message
        do_reset();
        send_byte(8'hA5, 4);
        RST = 1'b0;
        #2;
        chk("rst_msg_valid", {31'd0, Valid}, 32'd0);
        chk("rst_msg_crc", {31'd0, CRC}, 32'd0);
        step();
        RST = 1'b1;
        m = P_SEED;
        send_byte(8'h00, 8);
        drain("after_rst_msg", 8'h14);

        // Reset mid-output
        do_reset();
        send_byte(8'hFF, 8);
        Active = 1'b0;
        step();
        step();
        step();
        chk("mid_out_valid_before", {31'd0, Valid}, 32'd1);
        RST = 1'b0;
        #2;
        chk("rst_out_valid", {31'd0, Valid}, 32'd0);
        chk("rst_out_crc", {31'd0, CRC}, 32'd0);
        step();
        RST = 1'b1;
        m = P_SEED;
        send_byte(8'h00, 8);
        drain("after_rst_out", 8'h14);

        // Idle after reset never emits
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_valid", {31'd0, Valid}, 32'd0);
            chk("idle_crc", {31'd0, CRC}, 32'd0);
        end

        // Active raised during output cycle 3 aborts the burst
        b = 8'($urandom);
        send_byte(b, 8);
        Active = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("pre_abort_valid", {31'd0, Valid}, 32'd1);
            chk("pre_abort_bit", {31'd0, CRC}, {31'd0, m[0]});
            m = m >> 1;
        end
        b = 8'($urandom);
        send_byte(b, 8);
        e = m;
        drain("post_abort", e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
